cas_lock_seq_unit: RTL and testbench

Parametrised, clocked successor to the team's combinational CAS-Lock wrapper. It holds a 2N-bit key that is loaded serially and committed through a small key-management FSM. It evaluates two N-stage cascaded AND/OR chains (the primary and complement CAS blocks) and XORs the resulting corruption bit onto a protected output bus through one registered pipeline stage. The block sits between the original combinational netlist outputs and the locked design's output ports.

---
 rtl/cas_lock_seq_unit.sv | 146 ++++++++++++++
 tb/tb_cas_lock_seq_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/cas_lock_seq_unit.sv
// Clocked CAS-Lock wrapper: serial key load with a commit FSM and dual AND/OR cascade chains.
// The corruption bit is XORed onto the protected bus through one registered stage.
module cas_lock_seq_unit #(
  parameter int unsigned    N        = 32,
  parameter int unsigned    OUT_W    = 1,
  parameter logic [N-1:0]   CFG      = '0,
  parameter logic [N-1:0]   POL_A    = '0,
  parameter logic [N-1:0]   POL_B    = '0,
  parameter bit             FLIP_ALL = 1'b1,
  parameter int unsigned    OUT_SEL  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_sin,
  input  logic             key_shift,
  input  logic             key_commit,
  input  logic             key_clear,
  input  logic [N-1:0]     x_in,
  input  logic [OUT_W-1:0] f_in,
  input  logic             in_valid,
  output logic [OUT_W-1:0] f_out,
  output logic             out_valid,
  output logic [1:0]       key_state,
  output logic             load_err
);

  localparam int unsigned CW = $clog2(2 * N + 2);
  localparam logic [CW-1:0] CntFull = CW'(2 * N);
  localparam logic [CW-1:0] CntMax  = CW'(2 * N + 1);

  typedef enum logic [1:0] {
    StLocked  = 2'd0,
    StLoading = 2'd1,
    StArmed   = 2'd2,
    StError   = 2'd3
  } state_e;

  state_e           r_state;
  logic [2*N-1:0]   r_key_sr;
  logic [CW-1:0]    r_cnt;
  logic             r_load_err;
  logic [OUT_W-1:0] r_f_out;
  logic             r_out_valid;

  logic [N-1:0]     w_ka, w_kb, w_a, w_b, w_ca, w_cb;
  logic             w_casop, w_flip;
  logic [OUT_W-1:0] w_mask;
  logic [CW-1:0]    w_cnt_inc;

  assign w_ka      = r_key_sr[N-1:0];
  assign w_kb      = r_key_sr[2*N-1:N];
  assign w_cnt_inc = (r_cnt == CntMax) ? r_cnt : r_cnt + 1'b1;

  always_comb begin
    w_a  = x_in ^ w_ka ^ POL_A;
    w_b  = x_in ^ w_kb ^ POL_B;
    w_ca = '0;
    w_cb = '0;
    w_ca[0] = w_a[0];
    w_cb[0] = w_b[0];
    for (int i = 1; i < N; i++) begin
      w_ca[i] = CFG[i] ? (w_a[i] | w_ca[i-1]) : (w_a[i] & w_ca[i-1]);
      w_cb[i] = CFG[i] ? (w_b[i] | w_cb[i-1]) : (w_b[i] & w_cb[i-1]);
    end
    w_casop = w_ca[N-1] & ~w_cb[N-1];
  end

  always_comb begin
    w_flip = (r_state == StArmed) ? w_casop : 1'b1;
    w_mask = '0;
    if (FLIP_ALL) begin
      w_mask = {OUT_W{w_flip}};
    end else begin
      w_mask[OUT_SEL] = w_flip;
    end
  end

  // Key-management FSM; clear has priority over every other request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StLocked;
      r_key_sr   <= '0;
      r_cnt      <= '0;
      r_load_err <= 1'b0;
    end else if (key_clear) begin
      r_state    <= StLocked;
      r_key_sr   <= '0;
      r_cnt      <= '0;
      r_load_err <= 1'b0;
    end else begin
      unique case (r_state)
        StLocked: begin
          if (key_commit) begin
            r_state    <= StError;
            r_load_err <= 1'b1;
          end else if (key_shift) begin
            r_key_sr <= {r_key_sr[2*N-2:0], key_sin};
            r_cnt    <= CW'(1);
            r_state  <= StLoading;
          end
        end
        StLoading: begin
          if (key_shift) begin
            r_key_sr <= {r_key_sr[2*N-2:0], key_sin};
            r_cnt    <= w_cnt_inc;
            if (key_commit || (w_cnt_inc == CntMax)) begin
              r_state    <= StError;
              r_load_err <= 1'b1;
            end
          end else if (key_commit) begin
            if (r_cnt == CntFull) begin
              r_state <= StArmed;
            end else begin
              r_state    <= StError;
              r_load_err <= 1'b1;
            end
          end
        end
        StArmed: ;
        StError: ;
        default: begin
          r_state    <= StError;
          r_load_err <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f_out     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_f_out <= f_in ^ w_mask;
      end
    end
  end

  assign f_out     = r_f_out;
  assign out_valid = r_out_valid;
  assign key_state = r_state;
  assign load_err  = r_load_err;

endmodule

// File: tb/tb_cas_lock_seq_unit.sv
// Directed bench for cas_lock_seq_unit with N=4, CFG=0110, POL_B=1111; expected values are
// hand-computed from the chain equations.
module tb_cas_lock_seq_unit;

  localparam int unsigned N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_sin = 1'b0, key_shift = 1'b0, key_commit = 1'b0, key_clear = 1'b0;
  logic [3:0] x_in = '0;
  logic [0:0] f_in = '0;
  logic       in_valid = 1'b0;
  logic [0:0] f_out;
  logic       out_valid;
  logic [1:0] key_state;
  logic       load_err;

  int n_checks = 0;
  int n_fail   = 0;

  cas_lock_seq_unit #(
    .N       (N),
    .OUT_W   (1),
    .CFG     (4'b0110),
    .POL_A   (4'b0000),
    .POL_B   (4'b1111),
    .FLIP_ALL(1'b1),
    .OUT_SEL (0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_sin   (key_sin),
    .key_shift (key_shift),
    .key_commit(key_commit),
    .key_clear (key_clear),
    .x_in      (x_in),
    .f_in      (f_in),
    .in_valid  (in_valid),
    .f_out     (f_out),
    .out_valid (out_valid),
    .key_state (key_state),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bit(input logic b);
    key_sin   = b;
    key_shift = 1'b1;
    tick();
    key_shift = 1'b0;
  endtask

  task automatic shift_byte(input logic [7:0] v, input int nbits);
    for (int i = 0; i < nbits; i++) shift_bit(v[7-i]);
  endtask

  task automatic commit();
    key_commit = 1'b1;
    tick();
    key_commit = 1'b0;
  endtask

  task automatic clear();
    key_clear = 1'b1;
    tick();
    key_clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset state and masked output
    #12;
    check_eq("rst_f_out", f_out, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_key_state", key_state, 0);
    check_eq("rst_load_err", load_err, 0);
    rst_n = 1'b1;
    tick();
    in_valid = 1'b1; f_in = 1'b1; x_in = 4'h3;
    tick();
    check_eq("locked_f_out", f_out, 0);
    check_eq("locked_out_valid", out_valid, 1);
    check_eq("locked_state", key_state, 0);
    in_valid = 1'b0;

    // 2: correct key 0x5A, commit latency, full x sweep
    shift_byte(8'h5A, 8);
    check_eq("loading_state", key_state, 1);
    in_valid = 1'b1; f_in = 1'b1; x_in = 4'h0;
    commit();
    check_eq("commit_edge_masked", f_out, 0);
    check_eq("armed_state", key_state, 2);
    check_eq("armed_key_sr", dut.r_key_sr, 8'h5A);
    tick();
    check_eq("commit_next_unmasked", f_out, 1);
    for (int i = 0; i < 16; i++) begin
      x_in = 4'(i);
      f_in = 1'(i);
      tick();
      check_eq($sformatf("sweep_x%0d", i), f_out, i & 1);
    end
    in_valid = 1'b0;

    // 3: wrong key 0xAA
    clear();
    check_eq("clear_state", key_state, 0);
    shift_byte(8'hAA, 8);
    commit();
    check_eq("wrong_armed_state", key_state, 2);
    in_valid = 1'b1; x_in = 4'b0101; f_in = 1'b1;
    tick();
    check_eq("wrong_x5_f1", f_out, 0);
    f_in = 1'b0;
    tick();
    check_eq("wrong_x5_f0", f_out, 1);
    x_in = 4'b1010; f_in = 1'b1;
    tick();
    check_eq("wrong_xA_f1", f_out, 1);
    // clear at edge k: sample at k still armed, masking from k+1
    key_clear = 1'b1;
    tick();
    key_clear = 1'b0;
    check_eq("clear_edge_f_out", f_out, 1);
    tick();
    check_eq("after_clear_f_out", f_out, 0);
    in_valid = 1'b0;

    // 4: short load then commit -> sticky ERROR
    shift_byte(8'hFF, 7);
    commit();
    check_eq("short_err_state", key_state, 3);
    check_eq("short_err_flag", load_err, 1);
    shift_bit(1'b1);
    commit();
    check_eq("err_sticky_state", key_state, 3);
    check_eq("err_sticky_cnt", dut.r_cnt, 7);
    clear();
    check_eq("err_clear_state", key_state, 0);
    check_eq("err_clear_flag", load_err, 0);
    check_eq("err_clear_key_sr", dut.r_key_sr, 0);

    // 5: overflow, clear-beats-shift, commit from LOCKED
    shift_byte(8'h5A, 8);
    check_eq("ovf_8_state", key_state, 1);
    shift_bit(1'b0);
    check_eq("ovf_9_state", key_state, 3);
    check_eq("ovf_9_err", load_err, 1);
    clear();
    shift_byte(8'hE0, 3);
    key_clear = 1'b1; key_shift = 1'b1; key_sin = 1'b1;
    tick();
    key_clear = 1'b0; key_shift = 1'b0;
    check_eq("clr_shift_state", key_state, 0);
    check_eq("clr_shift_cnt", dut.r_cnt, 0);
    check_eq("clr_shift_key_sr", dut.r_key_sr, 0);
    commit();
    check_eq("locked_commit_err", key_state, 3);
    clear();
    key_shift = 1'b1; key_commit = 1'b1; key_sin = 1'b1;
    tick();
    key_shift = 1'b0; key_commit = 1'b0;
    check_eq("locked_shift_commit_err", key_state, 3);
    clear();

    // 6: async reset mid-stream while armed
    shift_byte(8'h5A, 8);
    commit();
    in_valid = 1'b1; f_in = 1'b1; x_in = 4'h9;
    tick();
    check_eq("pre_rst_f_out", f_out, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_f_out", f_out, 0);
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_state", key_state, 0);
    check_eq("midrst_key_sr", dut.r_key_sr, 0);
    #2 rst_n = 1'b1;
    tick();
    check_eq("post_rst_f1", f_out, 0);
    f_in = 1'b0;
    tick();
    check_eq("post_rst_f0", f_out, 1);
    check_eq("post_rst_valid", out_valid, 1);
    in_valid = 1'b0;
    tick();
    check_eq("hold_f_out", f_out, 1);
    check_eq("hold_out_valid", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
